// File: rtl/stoch_io_pkg.sv
// Shared types and frame geometry for the stochastic-core result capture path.
package stoch_io_pkg;

    localparam int FRAME_LEN   = 10;
    localparam int DATA_W      = 9;
    localparam int GUARD_PHASE = 9;
    localparam int PHASE_W     = 4;
    localparam int CNT_W       = 3;

    typedef logic [PHASE_W-1:0] phase_t;
    typedef logic [DATA_W-1:0]  word_t;
    typedef logic [CNT_W-1:0]   cnt_t;

    typedef enum logic [2:0] {
        IDLE,
        ARM,
        DISCARD,
        CAPTURE,
        HOLD
    } cap_state_t;

    function automatic phase_t next_phase(input phase_t p);
        return (p == phase_t'(FRAME_LEN - 1)) ? '0 : p + 1'b1;
    endfunction

endpackage

// File: rtl/serial_frame_shift.sv
// One serial result lane: LSB-first 9-bit shift register plus guard-bit sampling.
// The guard_hit port exists only when GUARD_CHECK_EN is defined.
module serial_frame_shift
    import stoch_io_pkg::*;
(
    input  logic   clk,
    input  logic   rst_n,
    input  logic   ser,
    input  phase_t phase,
    output word_t  word
`ifdef GUARD_CHECK_EN
    ,
    output logic   guard_hit
`endif
);

    word_t sr_q;

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sr_q <= '0;
        end else if (phase < phase_t'(DATA_W)) begin
            sr_q <= {ser, sr_q[DATA_W-1:1]};
        end
    end

    assign word = sr_q;

`ifdef GUARD_CHECK_EN
    assign guard_hit = (phase == phase_t'(GUARD_PHASE)) && ser;
`endif

endmodule

// File: rtl/stoch_result_deserializer.sv
// Captures one settled frame per channel per epoch and hands the three words to a host.
// Define GUARD_CHECK_EN to flag guard bits sampled as 1 on frame_err; otherwise it is tied 0.
module stoch_result_deserializer
    import stoch_io_pkg::*;
#(
    parameter int unsigned PHASE_INIT    = 0,
    parameter int unsigned SETTLE_FRAMES = 1
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          ser_mul_in,
    input  logic          ser_add_in,
    input  logic          ser_smul_in,
    input  logic          epoch_in,
    input  logic          res_ready,
    input  logic          flag_clr,
    output logic          res_valid,
    output logic [DATA_W-1:0] res_mul,
    output logic [DATA_W-1:0] res_add,
    output logic [DATA_W-1:0] res_smul,
    output logic          overrun,
    output logic          frame_err
);

    phase_t     phase_q;
    cap_state_t state_q, state_d;
    cnt_t       cnt_q, cnt_d;
    logic       frame_end;
    logic       capture_en;
    logic       overrun_set;
    logic       overrun_q;
    word_t      word_mul, word_add, word_smul;
    word_t      res_mul_q, res_add_q, res_smul_q;

    assign frame_end = (phase_q == phase_t'(GUARD_PHASE));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            phase_q <= phase_t'(PHASE_INIT);
        end else begin
            phase_q <= next_phase(phase_q);
        end
    end

`ifdef GUARD_CHECK_EN
    logic [2:0] guard_hit;
`endif

    serial_frame_shift u_mul (
        .clk       (clk),
        .rst_n     (rst_n),
        .ser       (ser_mul_in),
        .phase     (phase_q),
        .word      (word_mul)
`ifdef GUARD_CHECK_EN
        ,
        .guard_hit (guard_hit[0])
`endif
    );

    serial_frame_shift u_add (
        .clk       (clk),
        .rst_n     (rst_n),
        .ser       (ser_add_in),
        .phase     (phase_q),
        .word      (word_add)
`ifdef GUARD_CHECK_EN
        ,
        .guard_hit (guard_hit[1])
`endif
    );

    serial_frame_shift u_smul (
        .clk       (clk),
        .rst_n     (rst_n),
        .ser       (ser_smul_in),
        .phase     (phase_q),
        .word      (word_smul)
`ifdef GUARD_CHECK_EN
        ,
        .guard_hit (guard_hit[2])
`endif
    );

    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        capture_en  = 1'b0;
        overrun_set = 1'b0;
        case (state_q)
            IDLE: begin
                if (epoch_in) state_d = ARM;
            end
            ARM: begin
                if (epoch_in) begin
                    state_d = ARM;
                end else if (frame_end) begin
                    state_d = DISCARD;
                    cnt_d   = cnt_t'(SETTLE_FRAMES);
                end
            end
            DISCARD: begin
                if (epoch_in) begin
                    state_d = ARM;
                end else if (frame_end) begin
                    cnt_d = cnt_q - 1'b1;
                    if (cnt_q == cnt_t'(1)) state_d = CAPTURE;
                end
            end
            CAPTURE: begin
                if (epoch_in) begin
                    state_d = ARM;
                end else if (frame_end) begin
                    capture_en = 1'b1;
                    state_d    = HOLD;
                end
            end
            HOLD: begin
                // A pulse coinciding with the handshake starts the next epoch instead of overrunning.
                if (res_ready) begin
                    state_d = epoch_in ? ARM : IDLE;
                end else if (epoch_in) begin
                    overrun_set = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            res_mul_q  <= '0;
            res_add_q  <= '0;
            res_smul_q <= '0;
            overrun_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            overrun_q <= overrun_set | (overrun_q & ~flag_clr);
            if (capture_en) begin
                res_mul_q  <= word_mul;
                res_add_q  <= word_add;
                res_smul_q <= word_smul;
            end
        end
    end

`ifdef GUARD_CHECK_EN
    logic frame_err_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            frame_err_q <= 1'b0;
        end else begin
            frame_err_q <= (|guard_hit) | (frame_err_q & ~flag_clr);
        end
    end

    assign frame_err = frame_err_q;
`else
    assign frame_err = 1'b0;
`endif

    assign res_valid = (state_q == HOLD);
    assign res_mul   = res_mul_q;
    assign res_add   = res_add_q;
    assign res_smul  = res_smul_q;
    assign overrun   = overrun_q;

endmodule

// File: tb/tb_stoch_result_deserializer.sv
// Scoreboard bench: serial frames driven from a phase-aligned generator, results checked on valid.
module tb_stoch_result_deserializer;
    import stoch_io_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        ser_mul_in, ser_add_in, ser_smul_in;
    logic        epoch_in = 1'b0;
    logic        res_ready = 1'b0;
    logic        flag_clr = 1'b0;
    logic        res_valid;
    logic [8:0]  res_mul, res_add, res_smul;
    logic        overrun, frame_err;

    stoch_result_deserializer dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .ser_mul_in  (ser_mul_in),
        .ser_add_in  (ser_add_in),
        .ser_smul_in (ser_smul_in),
        .epoch_in    (epoch_in),
        .res_ready   (res_ready),
        .flag_clr    (flag_clr),
        .res_valid   (res_valid),
        .res_mul     (res_mul),
        .res_add     (res_add),
        .res_smul    (res_smul),
        .overrun     (overrun),
        .frame_err   (frame_err)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int ph = 0;

    word_t w_mul = 9'h155, w_add = 9'h0AA, w_smul = 9'h1FF;
    logic  g_mul = 1'b0, g_add = 1'b0, g_smul = 1'b0;

    typedef struct {
        word_t mul;
        word_t add;
        word_t smul;
        int    due;
    } exp_t;
    exp_t sb[$];

    always @(posedge clk) cyc <= cyc + 1;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) ph <= 0;
        else        ph <= (ph == FRAME_LEN - 1) ? 0 : ph + 1;
    end

    // Frame generator: the bit for the phase the DUT samples at the next rising edge.
    always @(negedge clk) begin
        ser_mul_in  = (ph < DATA_W) ? w_mul[ph]  : g_mul;
        ser_add_in  = (ph < DATA_W) ? w_add[ph]  : g_add;
        ser_smul_in = (ph < DATA_W) ? w_smul[ph] : g_smul;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic wait_phase(input int p);
        @(negedge clk);
        while (ph != p) @(negedge clk);
    endtask

    task automatic pulse_epoch(input bit with_ready, input bit expect_res);
        wait_phase(3);
        epoch_in = 1'b1;
        if (with_ready) res_ready = 1'b1;
        if (expect_res) sb.push_back('{w_mul, w_add, w_smul, cyc + 1 + 26});
        @(negedge clk);
        epoch_in = 1'b0;
    endtask

    task automatic wait_result(input int limit);
        bit   got = 1'b0;
        exp_t e;
        for (int i = 0; i < limit; i++) begin
            if (res_valid) begin
                got = 1'b1;
                break;
            end
            @(negedge clk);
        end
        if (!got) begin
            check("result_timeout", 0, 1);
        end else if (sb.size() == 0) begin
            check("unexpected_valid", 1, 0);
        end else begin
            e = sb.pop_front();
            check("res_mul", res_mul, e.mul);
            check("res_add", res_add, e.add);
            check("res_smul", res_smul, e.smul);
            check("latency", cyc, e.due);
        end
    endtask

    task automatic quiet_window(input string tag, input int n);
        int seen = 0;
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            if (res_valid !== 1'b0) seen++;
        end
        check(tag, seen, 0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog expired at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        int bad;

        // Reset held, then released away from a clock edge.
        repeat (4) @(negedge clk);
        check("rst_valid", res_valid, 0);
        check("rst_words", {res_mul, res_add, res_smul}, 0);
        check("rst_flags", {overrun, frame_err}, 0);
        #2 rst_n = 1'b1;
        quiet_window("no_valid_without_epoch", 30);
        check("idle_words", {res_mul, res_add, res_smul}, 0);

        // Basic capture with ready high: valid for exactly one cycle.
        pulse_epoch(1'b1, 1'b1);
        wait_result(60);
        @(negedge clk);
        check("valid_one_cycle", res_valid, 0);
        check("words_retained", res_mul, 9'h155);

        // Backpressure: result held stable while ready is low.
        res_ready = 1'b0;
        w_mul = 9'h0F3; w_add = 9'h10C; w_smul = 9'h02D;
        pulse_epoch(1'b0, 1'b1);
        wait_result(60);
        bad = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (res_valid !== 1'b1 || res_mul !== 9'h0F3 || res_add !== 9'h10C || res_smul !== 9'h02D)
                bad++;
        end
        check("hold_stable", bad, 0);

        // Epoch while holding: overrun, result untouched.
        pulse_epoch(1'b0, 1'b0);
        check("overrun_set", overrun, 1);
        check("overrun_valid", res_valid, 1);
        check("overrun_words", {res_mul, res_add, res_smul}, {9'h0F3, 9'h10C, 9'h02D});
        flag_clr = 1'b1;
        @(negedge clk);
        flag_clr = 1'b0;
        check("overrun_clr", overrun, 0);
        wait_phase(3);
        epoch_in = 1'b1;
        flag_clr = 1'b1;
        @(negedge clk);
        epoch_in = 1'b0;
        flag_clr = 1'b0;
        check("overrun_set_wins", overrun, 1);
        flag_clr = 1'b1;
        @(negedge clk);
        flag_clr = 1'b0;
        check("overrun_clr2", overrun, 0);

        // Epoch on the handshake cycle: no overrun, new capture starts.
        w_mul = 9'h1A5; w_add = 9'h05A; w_smul = 9'h100;
        pulse_epoch(1'b1, 1'b1);
        check("hs_valid_drop", res_valid, 0);
        check("hs_no_overrun", overrun, 0);
        wait_result(60);
        @(negedge clk);
        check("hs_valid_one_cycle", res_valid, 0);

        // Restart during CAPTURE with words changed mid-frame.
        w_mul = 9'h155; w_add = 9'h0AA; w_smul = 9'h1FF;
        pulse_epoch(1'b1, 1'b0);
        wait_phase(0);
        wait_phase(0);
        wait_phase(2);
        w_mul = 9'h001; w_add = 9'h001; w_smul = 9'h001;
        pulse_epoch(1'b1, 1'b1);
        check("restart_no_flag", overrun, 0);
        wait_result(60);
        @(negedge clk);

        // Guard bit on the add channel.
        wait_phase(0);
        g_add = 1'b1;
        wait_phase(0);
        g_add = 1'b0;
        @(negedge clk);
`ifdef GUARD_CHECK_EN
        check("frame_err_set", frame_err, 1);
`else
        check("frame_err_tied", frame_err, 0);
`endif
        flag_clr = 1'b1;
        @(negedge clk);
        flag_clr = 1'b0;
        check("frame_err_clr", frame_err, 0);

        // Reset mid-capture aborts the epoch.
        pulse_epoch(1'b1, 1'b0);
        repeat (8) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("abort_valid", res_valid, 0);
        check("abort_words", {res_mul, res_add, res_smul}, 0);
        @(negedge clk);
        #2 rst_n = 1'b1;
        quiet_window("abort_no_valid", 60);
        check("sb_drained", sb.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
